// File: rtl/photonic_order_feeder.sv
// Risk-checked order FIFO feeding a photonic encoder: one order in flight,
// issued as a single-cycle strobe and retired by ack or by timeout.
`timescale 1ns/100ps
module photonic_order_feeder #(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] MAX_QTY     = 32'd1000000,
    parameter logic [15:0] ACK_TIMEOUT = 16'd200
) (
    input  logic         clk_156mhz,
    input  logic         reset_n,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] order_data,
    output logic         order_valid,
    input  logic         order_ack,
    output logic [4:0]   fifo_level,
    output logic [15:0]  reject_cnt,
    output logic [15:0]  timeout_cnt,
    output logic [31:0]  sent_cnt,
    output logic         busy
);

    localparam int         PW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]     level_q, level_d;
    logic [15:0]    wait_q, wait_d;
    logic [15:0]    reject_q, reject_d;
    logic [15:0]    timeout_q, timeout_d;
    logic [31:0]    sent_q, sent_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   fifo_mem [DEPTH];

    logic           accept;
    logic           qty_ok;
    logic           push;
    logic           pop;
    logic [15:0]    wait_inc;

    // in_ready looks only at registered occupancy: a pop in the same cycle does not free a slot early
    assign in_ready    = reset_n && (level_q != DEPTH_L);
    assign accept      = in_valid && in_ready;
    assign qty_ok      = (in_data[31:0] != 32'd0) && (in_data[31:0] <= MAX_QTY);
    assign push        = accept && qty_ok;
    assign pop         = (state_q == ST_IDLE) && (level_q != 5'd0);
    assign wait_inc    = wait_q + 16'd1;

    assign order_data  = data_q;
    assign order_valid = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign fifo_level  = level_q;
    assign reject_cnt  = reject_q;
    assign timeout_cnt = timeout_q;
    assign sent_cnt    = sent_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q + 5'(push) - 5'(pop);
        wait_d    = wait_q;
        reject_d  = reject_q;
        timeout_d = timeout_q;
        sent_d    = sent_q;
        data_d    = data_q;

        if (accept && !qty_ok) begin
            reject_d = sat_inc16(reject_q);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                wait_d = 16'd0;
                if (pop) begin
                    data_d   = fifo_mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_d  = 16'd0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // ack wins over a timeout landing in the same cycle
                if (order_ack) begin
                    sent_d  = sent_q + 32'd1;
                    state_d = ST_IDLE;
                end else if (wait_inc == ACK_TIMEOUT) begin
                    timeout_d = sat_inc16(timeout_q);
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_156mhz) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= 5'd0;
            wait_q    <= 16'd0;
            reject_q  <= 16'd0;
            timeout_q <= 16'd0;
            sent_q    <= 32'd0;
            data_q    <= 128'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            wait_q    <= wait_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
            sent_q    <= sent_d;
            data_q    <= data_d;
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by the pointers and level
    always_ff @(posedge clk_156mhz) begin
        if (reset_n && push) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_photonic_order_feeder.sv
// Directed bench for photonic_order_feeder with hand-computed expectations.
`timescale 1ns/100ps
module tb_photonic_order_feeder;

    logic         clk_156mhz = 1'b0;
    logic         reset_n;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] order_data;
    logic         order_valid;
    logic         order_ack;
    logic [4:0]   fifo_level;
    logic [15:0]  reject_cnt;
    logic [15:0]  timeout_cnt;
    logic [31:0]  sent_cnt;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    logic [127:0] issued [$];

    photonic_order_feeder dut (
        .clk_156mhz (clk_156mhz),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .order_data (order_data),
        .order_valid(order_valid),
        .order_ack  (order_ack),
        .fifo_level (fifo_level),
        .reject_cnt (reject_cnt),
        .timeout_cnt(timeout_cnt),
        .sent_cnt   (sent_cnt),
        .busy       (busy)
    );

    always #3.2 clk_156mhz = ~clk_156mhz;

    always @(negedge clk_156mhz) begin
        if (order_valid === 1'b1) begin
            vcnt++;
            issued.push_back(order_data);
        end
    end

    function automatic logic [127:0] mk(input logic [63:0] id, input logic [31:0] price,
                                        input logic [31:0] qty);
        return {id, price, qty};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_156mhz);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int w;
        logic hs;
        logic pend;

        reset_n   = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        order_ack = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", order_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_counters", {reject_cnt, timeout_cnt, sent_cnt}, 0);
        chk("rst_data", order_data, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Single order, issue latency and acknowledged retire
        in_data  = mk(64'h1, 32'd50, 32'd100);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_level", fifo_level, 1);
        chk("t1_early_valid", order_valid, 0);
        step();
        chk("t1_valid", order_valid, 1);
        chk("t1_data", order_data, mk(64'h1, 32'd50, 32'd100));
        chk("t1_busy", busy, 1);
        step();
        chk("t1_strobe_len", order_valid, 0);
        repeat (128) step();
        order_ack = 1'b1;
        step();
        order_ack = 1'b0;
        chk("t1_sent", sent_cnt, 1);
        chk("t1_idle", busy, 0);
        chk("t1_data_hold", order_data, mk(64'h1, 32'd50, 32'd100));

        // Risk rejects: zero and over-limit quantities
        in_data  = mk(64'h2, 32'd9, 32'd0);
        in_valid = 1'b1;
        step();
        chk("t2_rej1", reject_cnt, 1);
        in_data = mk(64'h3, 32'd9, 32'd1000001);
        step();
        in_valid = 1'b0;
        v0 = vcnt;
        repeat (3) step();
        chk("t2_rej2", reject_cnt, 2);
        chk("t2_level", fifo_level, 0);
        chk("t2_no_valid", vcnt, v0);

        // Back-pressure with ack withheld, then drain in order
        issued.delete();
        for (int k = 0; k < 5; k++) begin
            in_data  = mk(64'(10 + k), 32'd7, 32'(k + 1));
            in_valid = 1'b1;
            chk("t3_rdy", in_ready, 1);
            step();
        end
        in_data = mk(64'd15, 32'd7, 32'd6);
        chk("t3_full_rdy", in_ready, 0);
        chk("t3_full_level", fifo_level, 4);
        order_ack = 1'b1;
        pend = 1'b0;
        for (int c = 0; c < 40; c++) begin
            hs = in_valid && in_ready;
            step();
            if (hs) in_valid = 1'b0;
            order_ack = 1'b0;
            if (pend) begin
                order_ack = 1'b1;
                pend = 1'b0;
            end
            if (order_valid) pend = 1'b1;
            if (fifo_level == 5'd4) chk("t3_full_no_lookahead", in_ready, 0);
        end
        order_ack = 1'b0;
        chk("t3_issued", issued.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < issued.size())
                chk("t3_order", issued[k], mk(64'(10 + k), 32'd7, 32'(k + 1)));
        end
        chk("t3_sent", sent_cnt, 7);
        chk("t3_level", fifo_level, 0);

        // Timeout after exactly ACK_TIMEOUT cycles; qty == MAX_QTY admitted
        in_data  = mk(64'd20, 32'd1, 32'd1000000);
        in_valid = 1'b1;
        step();
        in_data = mk(64'd21, 32'd1, 32'd5);
        step();
        in_valid = 1'b0;
        w = 0;
        while (!order_valid && w < 10) begin
            step();
            w++;
        end
        chk("t4_issue", order_valid, 1);
        chk("t4_data", order_data, mk(64'd20, 32'd1, 32'd1000000));
        repeat (200) step();
        chk("t4_not_yet", timeout_cnt, 0);
        chk("t4_still_busy", busy, 1);
        step();
        chk("t4_timeout", timeout_cnt, 1);
        chk("t4_idle", busy, 0);
        step();
        chk("t4_next_valid", order_valid, 1);
        chk("t4_next_data", order_data, mk(64'd21, 32'd1, 32'd5));

        // Ack coincident with the timeout cycle counts as success
        repeat (200) step();
        order_ack = 1'b1;
        step();
        order_ack = 1'b0;
        chk("t5_sent", sent_cnt, 8);
        chk("t5_timeout", timeout_cnt, 1);
        chk("t5_idle", busy, 0);

        // Stray ack in IDLE ignored
        order_ack = 1'b1;
        step();
        order_ack = 1'b0;
        step();
        chk("t5_stray_ack", sent_cnt, 8);

        // Reset while waiting with three queued
        for (int k = 0; k < 4; k++) begin
            in_data  = mk(64'(30 + k), 32'd3, 32'd10);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("t6_level", fifo_level, 3);
        chk("t6_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rdy_in_rst", in_ready, 0);
        step();
        reset_n = 1'b1;
        #1;
        chk("t6_counters", {reject_cnt, timeout_cnt, sent_cnt}, 0);
        chk("t6_level0", fifo_level, 0);
        chk("t6_busy0", busy, 0);
        chk("t6_data0", order_data, 0);
        chk("t6_rdy", in_ready, 1);
        v0 = vcnt;
        step();
        step();
        chk("t6_no_valid", vcnt, v0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/photonic_order_feeder.md
PHOTONIC_ORDER_FEEDER -- requirements
Module: photonic_order_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter MAX_QTY, default 32'd1000000: largest admissible quantity.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16'd200: cycles to wait for order_ack after issue.
REQ-004 SHALL have port clk_156mhz  in  1  single 156.25MHz clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_data  in  128  incoming order; [31:0] qty, [63:32] price, [127:64] order id.
REQ-007 SHALL have port in_valid  in  1  in_data valid.
REQ-008 SHALL have port in_ready  out  1  feeder can accept in_data this cycle.
REQ-009 SHALL have port order_data  out  128  order presented to the downstream photonic encoder.
REQ-010 SHALL have port order_valid  out  1  one-cycle issue strobe to the encoder.
REQ-011 SHALL have port order_ack  in  1  one-cycle completion pulse from the encoder.
REQ-012 SHALL have port fifo_level  out  5  number of occupied FIFO entries.
REQ-013 SHALL have port reject_cnt  out  16  risk-rejected orders, saturating.
REQ-014 SHALL have port timeout_cnt  out  16  ack timeouts, saturating.
REQ-015 SHALL have port sent_cnt  out  32  acknowledged orders, wrapping.
REQ-016 SHALL have port busy  out  1  high outside IDLE.

Function
REQ-017 SHALL drive in_ready = (fifo_level != DEPTH), combinationally from registered state only.
REQ-018 SHALL treat in_valid & in_ready as an accepted handshake.
REQ-019 SHALL risk-check each accepted order: qty == 0 or qty > MAX_QTY rejects it.
REQ-020 SHALL NOT write a rejected order to the FIFO; it SHALL increment reject_cnt, saturating at 16'hFFFF.
REQ-021 SHALL write each passing accepted order into the FIFO tail; fifo_level updates on the next cycle.
REQ-022 SHALL implement FSM states IDLE, ISSUE and WAIT_ACK.
REQ-023 In IDLE with fifo_level != 0, the FSM SHALL pop the head into order_data and go to ISSUE.
REQ-024 In ISSUE, order_valid SHALL be 1 for exactly this one cycle, with order_data stable; the FSM SHALL then go to WAIT_ACK.
REQ-025 order_data SHALL hold its value from the pop until the next pop.
REQ-026 In WAIT_ACK, order_ack = 1 SHALL increment sent_cnt (wrapping) and return the FSM to IDLE.
REQ-027 In WAIT_ACK, a wait counter reaching ACK_TIMEOUT without an ack SHALL drop the order, increment timeout_cnt (saturating) and return the FSM to IDLE.
REQ-028 Minimum spacing between order_valid strobes SHALL be 3 cycles (ISSUE, WAIT_ACK, IDLE).
REQ-029 order_ack outside WAIT_ACK SHALL be ignored.
REQ-030 A push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-031 When full, in_ready SHALL be 0 even if a pop occurs that cycle; no look-ahead.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strictly first-in, first-out.
REQ-033 An ack arriving in the same cycle the wait counter reaches ACK_TIMEOUT SHALL count as success, not timeout.

Reset
REQ-034 When reset_n = 0 at a rising edge, the block SHALL set FSM = IDLE and clear pointers, fifo_level, wait counter, reject_cnt, timeout_cnt, sent_cnt, order_valid, busy and order_data.
REQ-035 Reset mid-operation SHALL discard all queued and in-flight orders, with no order_valid in the following cycle.
REQ-036 in_ready SHALL be 0 while reset_n = 0 and 1 in the first cycle after release.

Verification
REQ-037 Bench: single order, qty = 100 → order_valid 2 cycles after the handshake; ack 130 cycles later → sent_cnt = 1, busy = 0.
REQ-038 Bench: qty = 0 and qty = 1000001 offered → reject_cnt = 2, fifo_level stays 0, no order_valid.
REQ-039 Bench: 6 back-to-back valid orders, ack withheld → in_ready drops after 4 are stored (1 popped, 4 queued); issue order matches input order.
REQ-040 Bench: no ack → timeout_cnt = 1 after exactly ACK_TIMEOUT cycles in WAIT_ACK; the next queued order issues.
REQ-041 Bench: ack coincident with the timeout cycle → sent_cnt increments, timeout_cnt unchanged.
REQ-042 Bench: reset_n pulsed low while in WAIT_ACK with 3 queued → all counters 0, fifo_level 0, no order_valid for 2 cycles after release.
